// File: rtl/roll_controller.sv
// roll_controller: two-die roll sequencer fed by synchronized, debounced push-buttons.
// Defining ROUND_CNT_EN adds a 4-bit "rounds" output that counts entries into SUM.
module roll_controller #(
    parameter int unsigned DEBOUNCE_CYCLES = 16,
    parameter int unsigned ROLL_CYCLES     = 64
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] btn,
    input  logic [4:0] rand1,
    input  logic [4:0] rand2,
    output logic       en1,
    output logic       en2,
    output logic [5:0] led,
    output logic       busy,
`ifdef ROUND_CNT_EN
    output logic [3:0] rounds,
`endif
    output logic [2:0] dbg_state_o
);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_ROLL_A = 3'd1;
    localparam logic [2:0] ST_SHOW_A = 3'd2;
    localparam logic [2:0] ST_ROLL_B = 3'd3;
    localparam logic [2:0] ST_SHOW_B = 3'd4;
    localparam logic [2:0] ST_SUM    = 3'd5;

    localparam logic [15:0] DB_LAST   = 16'(DEBOUNCE_CYCLES - 1);
    localparam logic [7:0]  ROLL_LOAD = 8'(ROLL_CYCLES);

    logic [2:0]  sync1_q, sync2_q;
    logic [2:0]  db_lvl_q, db_lvl_d, db_prev_q;
    logic [15:0] db_cnt_q [3];
    logic [15:0] db_cnt_d [3];
    logic [2:0]  press, ev;

    logic [2:0]  state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [4:0]  a_q, a_d, b_q, b_d;
    logic [5:0]  led_q, led_d;
    logic        en1_q, en1_d, en2_q, en2_d;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            db_lvl_q  <= '0;
            db_prev_q <= '0;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= '0;
        end else begin
            sync1_q   <= btn;
            sync2_q   <= sync1_q;
            db_lvl_q  <= db_lvl_d;
            db_prev_q <= db_lvl_q;
            for (int i = 0; i < 3; i++) db_cnt_q[i] <= db_cnt_d[i];
        end
    end

    // A level is accepted after DEBOUNCE_CYCLES consecutive samples that differ from it.
    always_comb begin
        db_lvl_d = db_lvl_q;
        for (int i = 0; i < 3; i++) begin
            db_cnt_d[i] = '0;
            if (sync2_q[i] != db_lvl_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) db_lvl_d[i] = sync2_q[i];
                else                        db_cnt_d[i] = db_cnt_q[i] + 16'd1;
            end
        end
    end

    assign press = db_lvl_q & ~db_prev_q;
    assign ev    = (press == 3'b001 || press == 3'b010 || press == 3'b100) ? press : 3'b000;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            ST_ROLL_A: begin
                if (cnt_q == 8'd1) begin
                    a_d     = rand1;
                    cnt_d   = '0;
                    state_d = ST_SHOW_A;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            ST_ROLL_B: begin
                if (cnt_q == 8'd1) begin
                    b_d     = rand2;
                    cnt_d   = '0;
                    state_d = ST_SHOW_B;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end
            default: begin
                if (ev[0]) begin
                    state_d = ST_ROLL_A;
                    a_d     = '0;
                    b_d     = '0;
                    cnt_d   = ROLL_LOAD;
                end else if (ev[1] && (state_q == ST_SHOW_A || state_q == ST_SHOW_B)) begin
                    state_d = ST_ROLL_B;
                    b_d     = '0;
                    cnt_d   = ROLL_LOAD;
                end else if (ev[2] && state_q == ST_SHOW_B) begin
                    state_d = ST_SUM;
                end
            end
        endcase
        en1_d = (state_d == ST_ROLL_A);
        en2_d = (state_d == ST_ROLL_B);
    end

    // The display follows the state register, so it trails each transition by one cycle.
    always_comb begin
        case (state_q)
            ST_SHOW_A: led_d = {1'b0, a_q};
            ST_SHOW_B: led_d = {1'b0, b_q};
            ST_SUM:    led_d = {1'b0, a_q} + {1'b0, b_q};
            default:   led_d = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            led_q   <= '0;
            en1_q   <= 1'b0;
            en2_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            led_q   <= led_d;
            en1_q   <= en1_d;
            en2_q   <= en2_d;
        end
    end

`ifdef ROUND_CNT_EN
    logic [3:0] rounds_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)                                         rounds_q <= '0;
        else if (state_d == ST_SUM && state_q != ST_SUM)  rounds_q <= rounds_q + 4'd1;
    end

    assign rounds = rounds_q;
`endif

    assign en1         = en1_q;
    assign en2         = en2_q;
    assign led         = led_q;
    assign busy        = (state_q == ST_ROLL_A) || (state_q == ST_ROLL_B);
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_roll_controller.sv
// Bench for roll_controller (DEBOUNCE_CYCLES=4, ROLL_CYCLES=8): directed button scenarios,
// a cycle-level reference model of the roll game, and literal checkpoints per scenario.
`timescale 1ns/1ps
module tb_roll_controller;

    localparam int DB = 4;
    localparam int RC = 8;
    localparam int ST_IDLE   = 0;
    localparam int ST_ROLL_A = 1;
    localparam int ST_SHOW_A = 2;
    localparam int ST_ROLL_B = 3;
    localparam int ST_SHOW_B = 4;
    localparam int ST_SUM    = 5;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic [2:0] btn   = 3'b000;
    logic [4:0] rand1 = 5'd0;
    logic [4:0] rand2 = 5'd0;
    logic       en1, en2, busy;
    logic [5:0] led;
    logic [2:0] dbg_state;
`ifdef ROUND_CNT_EN
    logic [3:0] rounds;
`endif

    int n_vec = 0;
    int n_err = 0;
    logic [4:0] want1 = 5'd0;
    logic [4:0] want2 = 5'd0;
    int en1_cycles = 0;
    int en2_cycles = 0;

    // Reference model state
    int         m_st     = ST_IDLE;
    int         m_rem    = 0;
    int         m_rounds = 0;
    int         m_nev    = 0;
    logic [4:0] m_a      = 5'd0;
    logic [4:0] m_b      = 5'd0;
    logic [5:0] m_led    = 6'd0;
    logic [5:0] m_led_n  = 6'd0;
    logic [2:0] m_lvl    = 3'b000;
    logic [2:0] m_press  = 3'b000;
    logic [2:0] m_samp   = 3'b000;
    logic       m_flip   = 1'b0;
    logic [2:0] pipe[$]  = '{3'b000, 3'b000};
    logic [2:0] hist[$];

    roll_controller #(
        .DEBOUNCE_CYCLES(DB),
        .ROLL_CYCLES    (RC)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .btn        (btn),
        .rand1      (rand1),
        .rand2      (rand2),
        .en1        (en1),
        .en2        (en2),
        .led        (led),
        .busy       (busy),
`ifdef ROUND_CNT_EN
        .rounds     (rounds),
`endif
        .dbg_state_o(dbg_state)
    );

    always #5 clk = ~clk;

    function automatic logic [5:0] led_of(input int st, input logic [4:0] a, input logic [4:0] b);
        case (st)
            ST_SHOW_A: return {1'b0, a};
            ST_SHOW_B: return {1'b0, b};
            ST_SUM:    return {1'b0, a} + {1'b0, b};
            default:   return 6'd0;
        endcase
    endfunction

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic press(input logic [2:0] m);
        btn = m;
        tick(10);
        btn = 3'b000;
        tick(20);
    endtask

    // Game rules: a press is seen the cycle after its debounced rise; a roll lasts RC cycles.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_st = ST_IDLE; m_rem = 0; m_rounds = 0;
            m_a = 5'd0; m_b = 5'd0; m_led = 6'd0;
            m_lvl = 3'b000; m_press = 3'b000;
            pipe = '{3'b000, 3'b000};
            hist.delete();
        end else begin
            m_led_n = led_of(m_st, m_a, m_b);
            m_nev = int'(m_press[0]) + int'(m_press[1]) + int'(m_press[2]);
            if (m_st == ST_ROLL_A) begin
                if (m_rem == 1) begin m_a = rand1; m_st = ST_SHOW_A; end
                else m_rem--;
            end else if (m_st == ST_ROLL_B) begin
                if (m_rem == 1) begin m_b = rand2; m_st = ST_SHOW_B; end
                else m_rem--;
            end else if (m_nev == 1) begin
                if (m_press[0]) begin
                    m_st = ST_ROLL_A; m_a = 5'd0; m_b = 5'd0; m_rem = RC;
                end else if (m_press[1] && (m_st == ST_SHOW_A || m_st == ST_SHOW_B)) begin
                    m_st = ST_ROLL_B; m_b = 5'd0; m_rem = RC;
                end else if (m_press[2] && m_st == ST_SHOW_B) begin
                    m_st = ST_SUM; m_rounds = (m_rounds + 1) % 16;
                end
            end
            m_led = m_led_n;
            pipe.push_back(btn);
            m_samp = pipe.pop_front();
            hist.push_back(m_samp);
            if (hist.size() > DB) void'(hist.pop_front());
            for (int i = 0; i < 3; i++) begin
                m_press[i] = 1'b0;
                if (hist.size() == DB) begin
                    m_flip = 1'b1;
                    foreach (hist[j]) if (hist[j][i] == m_lvl[i]) m_flip = 1'b0;
                    if (m_flip) begin
                        m_lvl[i]   = ~m_lvl[i];
                        m_press[i] = m_lvl[i];
                    end
                end
            end
        end
    end

    // RNG stand-ins: random every cycle except the cycle a capture is due.
    always @(posedge clk) begin
        #1;
        rand1 = (m_st == ST_ROLL_A && m_rem == 1) ? want1 : 5'($urandom_range(0, 31));
        rand2 = (m_st == ST_ROLL_B && m_rem == 1) ? want2 : 5'($urandom_range(0, 31));
    end

    always @(negedge clk) begin
        if (en1 === 1'b1) en1_cycles++;
        if (en2 === 1'b1) en2_cycles++;
        check("cyc_en1",   8'(en1),       8'(m_st == ST_ROLL_A));
        check("cyc_en2",   8'(en2),       8'(m_st == ST_ROLL_B));
        check("cyc_busy",  8'(busy),      8'(m_st == ST_ROLL_A || m_st == ST_ROLL_B));
        check("cyc_led",   8'(led),       8'(m_led));
        check("cyc_state", 8'(dbg_state), 8'(m_st));
`ifdef ROUND_CNT_EN
        check("cyc_rounds", 8'(rounds),   8'(m_rounds));
`endif
    end

    initial begin
        int e1;
        int e2;
        rst = 1'b0;
        btn = 3'b000;
        tick(3);
        check("rst_led",   8'(led),       8'd0);
        check("rst_en1",   8'(en1),       8'd0);
        check("rst_en2",   8'(en2),       8'd0);
        check("rst_busy",  8'(busy),      8'd0);
        check("rst_state", 8'(dbg_state), 8'(ST_IDLE));
        rst = 1'b1;
        tick(2);

        // Clean roll A
        want1 = 5'd19;
        e1 = en1_cycles;
        press(3'b001);
        check("a_en1_cycles", 8'(en1_cycles - e1), 8'd8);
        check("a_led",        8'(led),             8'd19);
        check("a_busy",       8'(busy),            8'd0);

        // Illegal and simultaneous presses in SHOW_A
        e2 = en2_cycles;
        press(3'b100);
        check("illegal_led",   8'(led),       8'd19);
        check("illegal_state", 8'(dbg_state), 8'(ST_SHOW_A));
        press(3'b011);
        check("simul_led",     8'(led),       8'd19);
        check("simul_state",   8'(dbg_state), 8'(ST_SHOW_A));
        check("simul_en2",     8'(en2_cycles - e2), 8'd0);

        // Full round
        want1 = 5'd7;
        press(3'b001);
        check("round_a", 8'(led), 8'd7);
        want2 = 5'd25;
        e2 = en2_cycles;
        press(3'b010);
        check("round_b",        8'(led),              8'd25);
        check("round_en2_cyc",  8'(en2_cycles - e2),  8'd8);
        press(3'b100);
        check("round_sum",   8'(led),       8'd32);
        check("round_state", 8'(dbg_state), 8'(ST_SUM));
`ifdef ROUND_CNT_EN
        check("round_cnt", 8'(rounds), 8'd1);
`endif

        // Bounce on btn[0]
        e1 = en1_cycles;
        for (int k = 0; k < 5; k++) begin
            btn = 3'b001; tick(2);
            btn = 3'b000; tick(2);
        end
        tick(10);
        check("bounce_en1",   8'(en1_cycles - e1), 8'd0);
        check("bounce_led",   8'(led),             8'd32);
        check("bounce_state", 8'(dbg_state),       8'(ST_SUM));

        // Reset in the third cycle of ROLL_B
        want1 = 5'd12;
        press(3'b001);
        check("mid_a", 8'(led), 8'd12);
        btn = 3'b010;
        for (int i = 0; i < 50 && m_st != ST_ROLL_B; i++) tick(1);
        check("mid_en2_up", 8'(en2), 8'd1);
        tick(2);
        rst = 1'b0;
        #1;
        check("mid_en2",   8'(en2),       8'd0);
        check("mid_led",   8'(led),       8'd0);
        check("mid_busy",  8'(busy),      8'd0);
        check("mid_state", 8'(dbg_state), 8'(ST_IDLE));
        btn = 3'b000;
        tick(3);
        rst = 1'b1;
        tick(2);
        e2 = en2_cycles;
        press(3'b010);
        check("post_b_state", 8'(dbg_state),       8'(ST_IDLE));
        check("post_b_en2",   8'(en2_cycles - e2), 8'd0);
        want1 = 5'd9;
        press(3'b001);
        check("post_a_led", 8'(led), 8'd9);

        // Maximum sum
        want1 = 5'd31;
        press(3'b001);
        want2 = 5'd31;
        press(3'b010);
        press(3'b100);
        check("max_sum", 8'(led), 8'd62);
`ifdef ROUND_CNT_EN
        check("max_rounds", 8'(rounds), 8'd1);
        for (int k = 0; k < 15; k++) begin
            want1 = 5'($urandom_range(0, 31));
            press(3'b001);
            want2 = 5'($urandom_range(0, 31));
            press(3'b010);
            press(3'b100);
            if (k == 13) check("rounds_15", 8'(rounds), 8'd15);
        end
        check("rounds_wrap", 8'(rounds), 8'd0);
`endif

        // Button held through reset release: press needs DB stable samples after sync
        rst = 1'b0;
        btn = 3'b001;
        tick(3);
        rst = 1'b1;
        tick(6);
        check("held_en1_early", 8'(en1), 8'd0);
        tick(1);
        check("held_en1_on", 8'(en1), 8'd1);
        btn = 3'b000;
        tick(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
